bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per iteration, then subtract 3 from every BCD nibble that is ≥ 8. It is the inverse companion of the team's binary-to-BCD converter, with the same `trigger`/`idle` handshake. It sits between digit-entry logic (keypad, switches, UART decimal input) and the binary datapath. One conversion runs at a time and takes a fixed number of cycles.

## Interface
- `DIGITS`, default 8: number of BCD digits; legal range 1..8; `W = 4*DIGITS`.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `trigger`  in  1  start request; sampled only in S_IDLE.
- `in`  in  W  packed BCD input; digit 0 in `[3:0]`.
- `idle`  out  1  high only in S_IDLE; low means a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bin` and `error` update.
- `bin`  out  W  binary result, zero-extended; held until the next `done`.
- `error`  out  1  invalid-digit flag, updated with `done` (see Configuration).

## Operation
- Working registers:
  - `bcd_r` (W bits), `bin_r` (W bits), and a 6-bit `counter`.
  - `in` is latched into `bcd_r` at the trigger edge; later changes to `in` are ignored.
- States (one-hot): S_IDLE, S_SHIFT, S_SUB3. Any illegal encoding goes to S_IDLE on the next edge.
- **S_IDLE:**
  - `idle=1`, `counter=1`, `bin_r=0`.
  - On `trigger=1`: latch `in` and go to S_SHIFT.
- **S_SHIFT:**
  - Shift `{bcd_r, bin_r}` right by 1: `bcd_r[0]` enters `bin_r[W-1]`, and `bcd_r[W-1]` receives 0.
  - If `counter == W`: the shifted `bin_r` is written to `bin`, `done=1`, go to S_IDLE.
  - Otherwise: `counter` increments and the FSM goes to S_SUB3.
- **S_SUB3:**
  - Each nibble of `bcd_r` with value ≥ 8 gets 3 subtracted, modulo 16 within the nibble; there is no borrow across nibbles.
  - Nibbles < 8 are unchanged. Go to S_SHIFT.
- Arithmetic:
  - For valid BCD, the result is the exact decimal value, always < 10^DIGITS < 2^W, so no overflow is possible.
  - Digit 0 is never adjusted before it fully shifts out, so it is treated as plain binary.
- Boundary conditions:
  - `trigger` while `idle=0` is ignored; no queueing.
  - `trigger` held high continuously gives back-to-back conversions, with one S_IDLE cycle between them.
  - `reset` asserted mid-conversion aborts it. State goes to S_IDLE and `bin`, `error`, `done` clear.
  - `reset` has priority over `trigger` in the same cycle.

## Timing
- Reset values: state=S_IDLE, `idle=1`, `done=0`, `bin=0`, `error=0`, `counter=1`.
- `trigger` sampled high at edge k (in S_IDLE):
  - `idle` is low from k through k+2W-1: W shifts plus W-1 subtract cycles, i.e. 63 cycles for DIGITS=8.
  - `bin` updates and `done` is high in the cycle after edge k+2W-1.
  - `idle` returns high in that same cycle.
- Throughput: one result per 2W cycles (64 for DIGITS=8).
- `bin` and `error` are stable between `done` pulses.

## Configuration
- Macro: `BCD_TO_BIN_CHECK_EN`.
- **Defined:** the latched input is checked at the trigger edge.
  - If any nibble > 9, the FSM skips the conversion and returns to S_IDLE on the next edge.
  - That edge pulses `done` with `error=1` and `bin=0`; latency is 1 cycle.
  - Valid inputs convert normally with `error=0`.
- **Undefined:** no check is made and `error` is tied to 0.
  - Invalid digits pass through the algorithm unchanged.
  - The result is whatever the shift/subtract sequence produces.

## Test plan
- Reset, then `in=0x00000000` with a 1-cycle trigger → `idle` low for 63 cycles, then `done` pulses with `bin=0` and `error=0`.
- `in=0x12345678` → `bin=0x00BC614E` (12345678), exactly 63 cycles after the trigger edge.
- `in=0x99999999` → `bin=0x05F5E0FF` (99999999). Then `trigger` pulsed mid-conversion → ignored, with exactly one `done` pulse.
- `in=0x00000042` converted, then `reset` asserted 20 cycles into the next conversion (`in=0x00000777`) → `bin=0`, `idle=1`, no `done`. A fresh trigger with 0x00000777 → `bin=777` (0x309).
- `in=0x0000000A`:
  - With `BCD_TO_BIN_CHECK_EN`: `done` at edge k+1 with `error=1` and `bin=0`.
  - Without it: `bin=10` and `error=0` after 63 cycles.
- `trigger` held high for 200 cycles with `in=0x00000001` → `done` pulses every 64 cycles, each with `bin=1`.

Source files
------------

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter using reverse double dabble.
// Each conversion alternates a right shift of {bcd, bin} with a per-nibble
// "subtract 3 if >= 8" step, giving W shifts and W-1 adjust steps.
// Optional feature macro: BCD_TO_BIN_CHECK_EN (rejects inputs with a nibble > 9).
module bcd_to_bin #(
   parameter int unsigned DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic [4*DIGITS-1:0]   in,
   output logic                  idle,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bin,
   output logic                  error
);

   localparam int unsigned W = 4 * DIGITS;

   typedef enum logic [2:0] {
      StIdle  = 3'b001,
      StShift = 3'b010,
      StSub3  = 3'b100
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   bcd_q, bcd_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [5:0]     counter_q, counter_d;
   logic [W-1:0]   bin_q, bin_d;
   logic           done_q, done_d;

   // Subtract 3 from every nibble >= 8, no borrow between nibbles.
   function automatic logic [W-1:0] sub3(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i+3]) begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd3;
         end
      end
      return r;
   endfunction

`ifdef BCD_TO_BIN_CHECK_EN
   logic chk_q, chk_d;
   logic err_q, err_d;

   // Any nibble above 9 makes the whole input invalid.
   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction
`endif

   // Next-state and datapath updates for the shift/adjust sequence.
   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      acc_d     = acc_q;
      counter_d = counter_q;
      bin_d     = bin_q;
      done_d    = 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
      chk_d     = chk_q;
      err_d     = err_q;
`endif
      case (state_q)
         StIdle: begin
            counter_d = 6'd1;
            acc_d     = '0;
            if (trigger) begin
               bcd_d   = in;
               state_d = StShift;
`ifdef BCD_TO_BIN_CHECK_EN
               chk_d   = has_bad_digit(in);
`endif
            end
         end
         StShift: begin
`ifdef BCD_TO_BIN_CHECK_EN
            if (chk_q) begin
               // Invalid input: report immediately without converting.
               bin_d   = '0;
               err_d   = 1'b1;
               done_d  = 1'b1;
               chk_d   = 1'b0;
               state_d = StIdle;
            end else begin
`endif
               bcd_d = {1'b0, bcd_q[W-1:1]};
               acc_d = {bcd_q[0], acc_q[W-1:1]};
               if (counter_q == 6'(W)) begin
                  bin_d   = acc_d;
                  done_d  = 1'b1;
                  state_d = StIdle;
`ifdef BCD_TO_BIN_CHECK_EN
                  err_d   = 1'b0;
`endif
               end else begin
                  counter_d = counter_q + 6'd1;
                  state_d   = StSub3;
               end
`ifdef BCD_TO_BIN_CHECK_EN
            end
`endif
         end
         StSub3: begin
            bcd_d   = sub3(bcd_q);
            state_d = StShift;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         bcd_q     <= '0;
         acc_q     <= '0;
         counter_q <= 6'd1;
         bin_q     <= '0;
         done_q    <= 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
         chk_q     <= 1'b0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         acc_q     <= acc_d;
         counter_q <= counter_d;
         bin_q     <= bin_d;
         done_q    <= done_d;
`ifdef BCD_TO_BIN_CHECK_EN
         chk_q     <= chk_d;
         err_q     <= err_d;
`endif
      end
   end

   assign idle = (state_q == StIdle);
   assign done = done_q;
   assign bin  = bin_q;
`ifdef BCD_TO_BIN_CHECK_EN
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Testbench for bcd_to_bin (DIGITS=8). Expected results come from a decimal
// model and flow through a scoreboard queue; timing is measured in cycles
// from the trigger edge. Honours BCD_TO_BIN_CHECK_EN when defined.
module tb_bcd_to_bin;

   localparam int DIGITS = 8;
   localparam int W      = 4 * DIGITS;

   logic          clk = 1'b0;
   logic          reset;
   logic          trigger;
   logic [W-1:0]  in_v;
   logic          idle;
   logic          done;
   logic [W-1:0]  bin;
   logic          error;

   typedef struct packed {
      logic [W-1:0] b;
      logic         e;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic idle_first;

   always #5 clk = ~clk;

   bcd_to_bin #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .reset   (reset),
      .trigger (trigger),
      .in      (in_v),
      .idle    (idle),
      .done    (done),
      .bin     (bin),
      .error   (error)
   );

   // Decimal value of the digits, most significant first.
   function automatic logic [W-1:0] dec_val(input logic [W-1:0] v);
      logic [W-1:0] acc;
      acc = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc = acc * 10 + W'(v[4*i +: 4]);
      end
      return acc;
   endfunction

   function automatic exp_t model(input logic [W-1:0] v);
      exp_t r;
`ifdef BCD_TO_BIN_CHECK_EN
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            r.b = '0;
            r.e = 1'b1;
            return r;
         end
      end
`endif
      r.b = dec_val(v);
      r.e = 1'b0;
      return r;
   endfunction

   function automatic bit sb_take(output exp_t e);
      if (sb.size() == 0) begin
         e = '0;
         return 1'b0;
      end
      e = sb.pop_front();
      return 1'b1;
   endfunction

   // Drive a one-cycle trigger; returns at the negedge after the trigger edge.
   task automatic start_conv(input logic [W-1:0] v);
      in_v    = v;
      trigger = 1'b1;
      sb.push_back(model(v));
      @(negedge clk);
      trigger    = 1'b0;
      idle_first = idle;
   endtask

   // Wait for done; n = cycles after the trigger edge's following negedge, -1 on timeout.
   task automatic wait_done(input int budget, output int n, output int idle_low);
      bit got;
      got      = 1'b0;
      n        = -1;
      idle_low = 0;
      for (int i = 1; i <= budget && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            n   = i;
         end else if (!idle) begin
            idle_low++;
         end
      end
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      trigger = 1'b1;
      in_v    = 32'h12345678;
      repeat (3) @(negedge clk);
      n_checks++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++;
      if (bin !== '0) begin n_fail++; $display("FAIL reset_bin got %h want 0", bin); end
      n_checks++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
      reset   = 1'b0;
      trigger = 1'b0;
      @(negedge clk);
      n_checks++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_prio_idle got %b want 1", idle); end
   endtask

   task automatic test_zero;
      int n, il;
      exp_t e;
      bit ok;
      start_conv(32'h0);
      n_checks++;
      if (idle_first !== 1'b0) begin n_fail++; $display("FAIL zero_idle_low got %b want 0", idle_first); end
      wait_done(200, n, il);
      n_checks++;
      if (n != 63) begin n_fail++; $display("FAIL zero_latency got %0d want 63", n); end
      n_checks++;
      if (il != 62) begin n_fail++; $display("FAIL zero_idle_span got %0d want 62", il); end
      n_checks++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL zero_idle_back got %b want 1", idle); end
      ok = sb_take(e);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL zero_sb got empty want entry"); end
      n_checks++;
      if (bin !== e.b) begin n_fail++; $display("FAIL zero_bin got %h want %h", bin, e.b); end
      n_checks++;
      if (error !== e.e) begin n_fail++; $display("FAIL zero_error got %b want %b", error, e.e); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got %b want 0", done); end
   endtask

   task automatic test_basic(input logic [W-1:0] v);
      int n, il;
      exp_t e;
      bit ok;
      start_conv(v);
      wait_done(200, n, il);
      n_checks++;
      if (n != 63) begin n_fail++; $display("FAIL basic_latency in=%h got %0d want 63", v, n); end
      ok = sb_take(e);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_sb in=%h got empty want entry", v); end
      n_checks++;
      if (bin !== e.b) begin n_fail++; $display("FAIL basic_bin in=%h got %h want %h", v, bin, e.b); end
      n_checks++;
      if (error !== e.e) begin n_fail++; $display("FAIL basic_error in=%h got %b want %b", v, error, e.e); end
      @(negedge clk);
   endtask

   task automatic test_ignore_trigger;
      int n, il;
      exp_t e;
      bit ok;
      logic [W-1:0] held;
      start_conv(32'h99999999);
      repeat (10) @(negedge clk);
      in_v    = 32'h11111111;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
      wait_done(200, n, il);
      n_checks++;
      if (n != 52) begin n_fail++; $display("FAIL ignore_latency got %0d want 52", n); end
      ok = sb_take(e);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ignore_sb got empty want entry"); end
      n_checks++;
      if (bin !== e.b) begin n_fail++; $display("FAIL ignore_bin got %h want %h", bin, e.b); end
      held = bin;
      wait_done(100, n, il);
      n_checks++;
      if (n != -1) begin n_fail++; $display("FAIL ignore_extra_done got %0d want none", n); end
      n_checks++;
      if (bin !== held) begin n_fail++; $display("FAIL ignore_bin_hold got %h want %h", bin, held); end
   endtask

   task automatic test_reset_abort;
      int n, il;
      test_basic(32'h00000042);
      start_conv(32'h00000777);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      n_checks++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL abort_idle got %b want 1", idle); end
      n_checks++;
      if (bin !== '0) begin n_fail++; $display("FAIL abort_bin got %h want 0", bin); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
      wait_done(100, n, il);
      n_checks++;
      if (n != -1) begin n_fail++; $display("FAIL abort_late_done got %0d want none", n); end
      test_basic(32'h00000777);
   endtask

   task automatic test_invalid;
      int n, il;
      exp_t e;
      bit ok;
      start_conv(32'h0000000A);
      wait_done(200, n, il);
`ifdef BCD_TO_BIN_CHECK_EN
      n_checks++;
      if (n != 1) begin n_fail++; $display("FAIL invalid_latency got %0d want 1", n); end
`else
      n_checks++;
      if (n != 63) begin n_fail++; $display("FAIL invalid_latency got %0d want 63", n); end
`endif
      ok = sb_take(e);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL invalid_sb got empty want entry"); end
      n_checks++;
      if (bin !== e.b) begin n_fail++; $display("FAIL invalid_bin got %h want %h", bin, e.b); end
      n_checks++;
      if (error !== e.e) begin n_fail++; $display("FAIL invalid_error got %b want %b", error, e.e); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n, il, last, ndone;
      exp_t e;
      bit ok;
      in_v    = 32'h00000001;
      trigger = 1'b1;
      sb.push_back(model(in_v));
      last    = -1;
      ndone   = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            ok = sb_take(e);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL b2b_sb at %0d got empty want entry", i); end
            n_checks++;
            if (bin !== e.b) begin n_fail++; $display("FAIL b2b_bin at %0d got %h want %h", i, bin, e.b); end
            if (last >= 0) begin
               n_checks++;
               if (i - last != 64) begin
                  n_fail++;
                  $display("FAIL b2b_period got %0d want 64", i - last);
               end
            end
            last = i;
         end
         if (idle && trigger) sb.push_back(model(in_v));
      end
      trigger = 1'b0;
      n_checks++;
      if (ndone != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", ndone); end
      wait_done(100, n, il);
      n_checks++;
      if (n != 56) begin n_fail++; $display("FAIL b2b_last_latency got %0d want 56", n); end
      ok = sb_take(e);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_last_sb got empty want entry"); end
      n_checks++;
      if (bin !== e.b) begin n_fail++; $display("FAIL b2b_last_bin got %h want %h", bin, e.b); end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_sb_left got %0d want 0", sb.size()); end
   endtask

   initial begin
      reset   = 1'b1;
      trigger = 1'b0;
      in_v    = '0;
      test_reset();
      test_zero();
      test_basic(32'h12345678);
      test_ignore_trigger();
      test_reset_abort();
      test_invalid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
